// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the iterative shift-and-add multiplier.
// No logic; constants only.
// No handshake; consumed by shift_add_multiplier and adder32.
package shift_add_multiplier_pkg;

  // Operand width; the datapath is hard-wired to the 32-bit adder32.
  localparam int WIDTH = 32;

  // Control states: waiting for operands, stepping, presenting the product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter type: 32 steps need 5 bits.
  typedef logic [4:0] count_t;

  // Index of the final shift-and-add step.
  localparam count_t STEP_LAST = 5'd31;

endpackage

// File: rtl/adder32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
// Purely combinational, zero cycles.
// No handshake; outputs follow inputs.
module adder32
  import shift_add_multiplier_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  localparam int GROUPS = 8;

  logic [31:0]       g;
  logic [31:0]       p;
  logic [32:0]       c;
  logic [GROUPS-1:0] grp_g;
  logic [GROUPS-1:0] grp_p;

  // Bit generate/propagate, in-group lookahead carries and group-level carry chain.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    c[0]  = cin;
    for (int i = 0; i < GROUPS; i++) begin
      c[4*i+1] = g[4*i]
               | (p[4*i] & c[4*i]);
      c[4*i+2] = g[4*i+1]
               | (p[4*i+1] & g[4*i])
               | (p[4*i+1] & p[4*i] & c[4*i]);
      c[4*i+3] = g[4*i+2]
               | (p[4*i+2] & g[4*i+1])
               | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
      grp_g[i] = g[4*i+3]
               | (p[4*i+3] & g[4*i+2])
               | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      grp_p[i] = &p[4*i +: 4];
      c[4*i+4] = grp_g[i] | (grp_p[i] & c[4*i]);
    end
    sum  = p ^ c[31:0];
    cout = c[32];
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned 32x32->64 radix-2 shift-and-add multiplier built on adder32.
// Latency: out_valid rises exactly 32 edges after the accepting edge; >=34 cycles per result.
// Backpressure: product/out_valid hold while out_ready=0; in_ready is low outside IDLE.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  // Only 32 is meaningful: the step adder is the fixed-width adder32.
  parameter int WIDTH = shift_add_multiplier_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  count_t           count;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] step_sum;
  logic             step_c;

  // acc_hi + mcand for the current step; the carry becomes bit 63 after the shift.
  adder32 u_adder (
    .a    (acc_hi),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Add the multiplicand only when the multiplier bit being retired is set.
  always_comb begin
    step_sum = acc_hi;
    step_c   = 1'b0;
    if (acc_lo[0]) begin
      step_sum = add_sum;
      step_c   = add_cout;
    end
  end

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus handshake outputs decoded from state only.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (count == STEP_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, one shift-and-add per BUSY edge, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            count  <= '0;
          end
        end
        BUSY: begin
          {acc_hi, acc_lo} <= {step_c, step_sum, acc_lo[WIDTH-1:1]};
          if (count != STEP_LAST) begin
            count <= count + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The accumulator pair is the product; meaningful only while out_valid is high.
  assign product = {acc_hi, acc_lo};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: vector table plus multi-cycle corner sequences.
// Expected products are pushed to a scoreboard at accept and compared at the output handshake.
// Stimulus driven and outputs sampled on the falling clock edge.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [63:0] sb_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          hold;
    bit          poke;
  } vec_t;

  vec_t vecs[8];

  shift_add_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h, want 0x%016h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pop the scoreboard head and compare against the current product.
  task automatic sb_compare(input string name);
    logic [63:0] exp;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s: got 0x%016h, want <scoreboard empty>", name, product);
    end else begin
      exp = sb_q.pop_front();
      tests--;
      check(name, product, exp);
    end
  endtask

  // One full operation: accept, 32-step latency check, optional backpressure, handshake.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic [63:0] exp,
                        input int hold, input bit poke, input string tag);
    int m;
    check({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    sb_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    check({tag, " in_ready after accept"}, 64'(in_ready), 64'd0);
    m = 0;
    while (!out_valid && m < 40) begin
      if (poke && m == 4) begin
        in_valid = 1'b1;
        a        = 32'd7;
        b        = 32'd7;
      end
      if (poke && m == 9) begin
        in_valid = 1'b0;
      end
      tick();
      m++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 64'(m), 64'd32);
    if (!out_valid) begin
      void'(sb_q.pop_back());
      return;
    end
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check({tag, " out_valid held"}, 64'(out_valid), 64'd1);
      check({tag, " product held"}, product, exp);
      tick();
    end
    out_ready = 1'b1;
    sb_compare({tag, " product"});
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready after handshake"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int acc_cyc[2];
    int nacc;
    int nres;

    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 0,  1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 0,  1'b0};
    vecs[2] = '{32'h1234_5678,  32'd0,          64'h0,                   0,  1'b0};
    vecs[3] = '{32'd0,          32'hDEAD_BEEF,  64'h0,                   0,  1'b0};
    vecs[4] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 10, 1'b0};
    vecs[5] = '{32'h0000_1234,  32'h0000_5678,  64'h0000_0000_0626_0060, 0,  1'b1};
    vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  64'h7FFF_FFFF_8000_0000, 2,  1'b0};
    vecs[7] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF, 0,  1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset product", product, 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, vecs[i].poke,
             $sformatf("vec%0d", i));
    end

    // Reset in the middle of an operation, then a fresh run of the same operands.
    in_valid = 1'b1;
    a        = 32'd9;
    b        = 32'd9;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd1);
    check("midreset product", product, 64'd0);
    run_op(32'd9, 32'd9, 64'h51, 0, 1'b0, "after_reset");

    // Back-to-back with in_valid held high and out_ready tied high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 32'd6;
    b         = 32'd7;
    nacc      = 0;
    nres      = 0;
    acc_cyc   = '{0, 0};
    for (int k = 0; k < 200 && nres < 2; k++) begin
      if (in_valid && in_ready && nacc < 2) begin
        acc_cyc[nacc] = cyc + 1;
        sb_q.push_back(nacc == 0 ? 64'h2A : 64'h8F);
        nacc++;
        tick();
        if (nacc == 1) begin
          a = 32'd11;
          b = 32'd13;
        end else begin
          in_valid = 1'b0;
        end
      end else if (out_valid && out_ready) begin
        sb_compare($sformatf("b2b result%0d", nres));
        nres++;
        tick();
      end else begin
        tick();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b results seen", 64'(nres), 64'd2);
    check("b2b accept spacing >= 34", 64'(acc_cyc[1] - acc_cyc[0] >= 34), 64'd1);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
